ecg_frame_feeder: RTL and testbench
===================================

ECG_FRAME_FEEDER -- requirements
Module: ecg_frame_feeder

Interface
REQ-001 SHALL have parameter FRAME_LEN, 16, samples per ECG frame streamed to the classifier core.
REQ-002 SHALL have parameter TIMEOUT, 4096, maximum cycles to wait for core_done after the last sample.
REQ-003 SHALL have clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1  host sample write request.
REQ-006 SHALL have in_data  input  8  host sample, signed.
REQ-007 SHALL have in_ready  output  1  feeder can accept a sample.
REQ-008 SHALL have core_start  output  1  one-cycle start pulse to the classifier core.
REQ-009 SHALL have ecg_out  output  8  signed sample stream to the classifier core.
REQ-010 SHALL have core_done  input  1  classifier core completion pulse.
REQ-011 SHALL have core_class  input  4  classifier core result, sampled when core_done=1.
REQ-012 SHALL have res_valid  output  1  result available.
REQ-013 SHALL have res_class  output  4  captured class index.
REQ-014 SHALL have res_timeout  output  1  result produced by timeout, not core_done.
REQ-015 SHALL have res_ready  input  1  host accepts result.

Function
REQ-016 SHALL hold two FRAME_LEN x 8-bit frame buffers (ping-pong); host fills one while the other streams.
REQ-017 SHALL accept a sample on a cycle where in_valid=1 and in_ready=1, writing it at the fill buffer's write index, then incrementing it.
REQ-018 SHALL mark a buffer full when its FRAME_LEN-th sample is written, reset its write index to 0, and switch filling to the other buffer.
REQ-019 SHALL drive in_ready=0 when both buffers are full; samples offered then are ignored and not lost from the host's view (host must hold).
REQ-020 SHALL implement FSM states IDLE, START, STREAM, WAIT, RESULT.
REQ-021 IDLE -> START when a full buffer exists and res_valid=0; otherwise stay IDLE.
REQ-022 START: core_start=1 for exactly this one cycle; next state STREAM with stream index 0.
REQ-023 STREAM: ecg_out = buffer[index] each cycle, index 0..FRAME_LEN-1 over FRAME_LEN consecutive cycles, first sample the cycle after core_start; after index FRAME_LEN-1, free that buffer and go WAIT.
REQ-024 ecg_out SHALL be 0 in every state other than STREAM.
REQ-025 WAIT: on core_done=1 capture core_class into res_class, res_timeout=0, go RESULT; core_done outside WAIT is ignored.
REQ-026 WAIT: cycle counter starts at 0 on entry; if it reaches TIMEOUT-1 without core_done, set res_class=0, res_timeout=1, go RESULT.
REQ-027 RESULT: res_valid=1, res_class/res_timeout stable until res_valid&&res_ready; then res_valid=0, go IDLE.
REQ-028 Buffer freed in STREAM on the same cycle the host completes the other buffer SHALL leave exactly one full buffer, no sample dropped.
REQ-029 Streaming order SHALL be oldest full buffer first; frames never reorder.
REQ-030 Latency from IDLE with a full buffer to last sample on ecg_out SHALL be FRAME_LEN+1 cycles.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, both buffers empty, write/stream indices 0, wait counter 0.
REQ-032 Reset values: in_ready=1, core_start=0, ecg_out=0, res_valid=0, res_class=0, res_timeout=0.
REQ-033 Reset mid-STREAM or mid-WAIT SHALL abort the frame; partial and full buffer contents are discarded.

Verification
REQ-034 Write samples 1..16 -> core_start pulse one cycle, then ecg_out 1,2,...,16 on 16 consecutive cycles, then 0.
REQ-035 Streamed frame, core_done=1 with core_class=4'd3 -> res_valid=1, res_class=3, res_timeout=0; held until res_ready=1.
REQ-036 Write 32 samples while first frame streams and result unconsumed -> in_ready=0 after 32nd; second frame starts only after res_ready handshake.
REQ-037 No core_done for TIMEOUT cycles in WAIT -> res_valid=1, res_class=0, res_timeout=1.
REQ-038 rst asserted at stream index 7 -> next cycle ecg_out=0, in_ready=1, res_valid=0; new 16-sample frame streams from its first sample.
REQ-039 core_done pulse during IDLE or STREAM -> no res_valid, no state change.

Source files
------------

// File: rtl/ecg_frame_feeder.sv
// ECG frame feeder: ping-pong frame buffers filled by the host and streamed to a
// classifier core with a start pulse, done/timeout capture and a held result.
module ecg_frame_feeder #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       core_start,
  output logic [7:0] ecg_out,
  input  logic       core_done,
  input  logic [3:0] core_class,
  output logic       res_valid,
  output logic [3:0] res_class,
  output logic       res_timeout,
  input  logic       res_ready
);

  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, RESULT} state_t;

  state_t        state;
  logic [7:0]    mem [2][FRAME_LEN];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          fill_sel;
  logic          stream_sel;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          wr_last;
  logic          rd_last;
  logic          release_buf;

  assign accept      = in_valid && in_ready;
  assign wr_last     = (wr_idx == LAST_IDX);
  assign rd_last     = (rd_idx == LAST_IDX);
  assign release_buf = (state == STREAM) && rd_last;

  // Freeing one buffer and completing the other can coincide; bits are independent.
  always_comb begin
    full_nxt = full;
    if (release_buf) full_nxt[stream_sel] = 1'b0;
    if (accept && wr_last) full_nxt[fill_sel] = 1'b1;
  end

  // Sample storage carries no reset: the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[fill_sel][wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      full        <= '0;
      fill_sel    <= 1'b0;
      stream_sel  <= 1'b0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      wait_cnt    <= '0;
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      ecg_out     <= '0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      res_timeout <= 1'b0;
    end else begin
      full       <= full_nxt;
      in_ready   <= ~&full_nxt;
      core_start <= 1'b0;
      ecg_out    <= '0;

      if (accept) begin
        wr_idx <= wr_last ? '0 : wr_idx + IW'(1);
        if (wr_last) fill_sel <= ~fill_sel;
      end

      // Outputs are loaded on the edge that enters each state so they line up with it.
      case (state)
        IDLE: begin
          if (full[stream_sel] && !res_valid) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: begin
          state   <= STREAM;
          rd_idx  <= '0;
          ecg_out <= mem[stream_sel][IW'(0)];
        end
        STREAM: begin
          if (rd_last) begin
            state      <= WAIT;
            wait_cnt   <= '0;
            stream_sel <= ~stream_sel;
          end else begin
            rd_idx  <= rd_idx + IW'(1);
            ecg_out <= mem[stream_sel][rd_idx + IW'(1)];
          end
        end
        WAIT: begin
          if (core_done) begin
            state       <= RESULT;
            res_valid   <= 1'b1;
            res_class   <= core_class;
            res_timeout <= 1'b0;
          end else if (wait_cnt == LAST_CNT) begin
            state       <= RESULT;
            res_valid   <= 1'b1;
            res_class   <= '0;
            res_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_frame_feeder.sv
// Bench for ecg_frame_feeder: a queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ecg_frame_feeder;

  localparam int unsigned FL = 16;
  localparam int unsigned TO = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       core_start;
  logic [7:0] ecg_out;
  logic       core_done;
  logic [3:0] core_class;
  logic       res_valid;
  logic [3:0] res_class;
  logic       res_timeout;
  logic       res_ready;

  ecg_frame_feeder #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_start(core_start), .ecg_out(ecg_out),
    .core_done(core_done), .core_class(core_class),
    .res_valid(res_valid), .res_class(res_class), .res_timeout(res_timeout),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: completed frames (oldest first, including the one streaming), a partial frame,
  // and an abstract phase: 0 idle, 1 start, 2 stream, 3 wait, 4 result.
  typedef logic [8*FL-1:0] frame_t;
  frame_t     held[$];
  logic [7:0] part[$];
  int         ph;
  int         pos;
  int         cnt;
  logic [3:0] m_class;
  logic       m_to;
  bit         model_on = 1'b0;
  int         m_nheld;
  bit         m_acc;
  frame_t     m_f;
  frame_t     c_f;
  logic [7:0] c_ecg;

  always @(posedge clk) begin
    if (rst) begin
      held.delete();
      part.delete();
      ph = 0; pos = 0; cnt = 0; m_class = '0; m_to = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_nheld = held.size();
      m_acc   = in_valid && (m_nheld < 2);
      case (ph)
        0: if (m_nheld > 0) ph = 1;
        1: begin ph = 2; pos = 0; end
        2: begin
          if (pos == FL - 1) begin
            void'(held.pop_front());
            ph = 3; cnt = 0;
          end else pos++;
        end
        3: begin
          if (core_done) begin m_class = core_class; m_to = 1'b0; ph = 4; end
          else if (cnt == TO - 1) begin m_class = '0; m_to = 1'b1; ph = 4; end
          else cnt++;
        end
        default: if (res_ready) ph = 0;
      endcase
      if (m_acc) begin
        part.push_back(in_data);
        if (part.size() == FL) begin
          for (int i = 0; i < FL; i++) m_f[8*i +: 8] = part[i];
          held.push_back(m_f);
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      c_ecg = 8'h00;
      if (ph == 2) begin
        c_f   = held[0];
        c_ecg = c_f[8*pos +: 8];
      end
      check("m_in_ready", in_ready, (held.size() < 2) ? 1 : 0);
      check("m_core_start", core_start, (ph == 1) ? 1 : 0);
      check("m_ecg_out", ecg_out, c_ecg);
      check("m_res_valid", res_valid, (ph == 4) ? 1 : 0);
      check("m_res_class", res_class, m_class);
      check("m_res_timeout", res_timeout, m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [7:0] d);
    bit ok;
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    ok = in_ready;
    tick();
    while (!ok && waited < 200) begin
      ok = in_ready;
      tick();
      waited++;
    end
    if (!ok) check("write_accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] base);
    for (int k = 1; k <= FL; k++) write_sample(8'(base + k));
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = core_start;
    end
    check(name, seen, 1);
  endtask

  task automatic expect_stream(input string name, input logic [7:0] base);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      check(name, ecg_out, 8'(base + k));
    end
  endtask

  task automatic pulse_done(input logic [3:0] cls);
    core_class = cls;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
  endtask

  task automatic pulse_ready();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  int  n_wait;
  bit  seen_rv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    core_done = 1'b0; core_class = '0; res_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_ecg_out", ecg_out, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_class", res_class, 0);
    check("rst_res_timeout", res_timeout, 0);
    tick();
    rst = 1'b0;

    // Basic frame 1..16, then a core_done result held until the handshake.
    write_frame(8'd0);
    wait_start("a_start");
    expect_stream("a_ecg", 8'd0);
    @(negedge clk);
    check("a_ecg_tail", ecg_out, 0);
    repeat (5) tick();
    pulse_done(4'd3);
    @(negedge clk);
    check("a_res_valid", res_valid, 1);
    check("a_res_class", res_class, 3);
    check("a_res_timeout", res_timeout, 0);
    repeat (5) tick();
    @(negedge clk);
    check("a_res_hold", res_valid, 1);
    check("a_class_hold", res_class, 3);
    pulse_ready();
    @(negedge clk);
    check("a_res_release", res_valid, 0);

    // core_done while idle must not produce a result.
    tick();
    pulse_done(4'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done_ignored", res_valid, 0);
    end

    // Three frames back to back, a stray core_done mid-stream, result left pending.
    write_frame(8'd16);
    for (int i = 0; i < 2 * FL; i++) begin
      core_done  = (i == 5);
      core_class = 4'hF;
      if (i < FL) write_sample(8'(33 + i));
      else        write_sample(8'(8'h81 + i - FL));
    end
    core_done = 1'b0;
    @(negedge clk);
    check("b_in_ready_full", in_ready, 0);
    check("b_no_result_yet", res_valid, 0);
    tick();
    pulse_done(4'd5);
    @(negedge clk);
    check("b_res_class", res_class, 5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_no_start_pending", core_start, 0);
      check("b_res_pending", res_valid, 1);
    end
    pulse_ready();
    wait_start("b_f2_start");
    expect_stream("b_f2_ecg", 8'd32);
    @(negedge clk);
    check("b_f2_tail", ecg_out, 0);
    check("b_in_ready_back", in_ready, 1);
    tick();
    pulse_done(4'd9);
    @(negedge clk);
    check("b_f2_class", res_class, 9);
    pulse_ready();
    wait_start("b_f3_start");
    expect_stream("b_f3_ecg", 8'h80);

    // No core_done: result must come from the timeout, TO wait cycles later.
    n_wait  = 0;
    seen_rv = 1'b0;
    while (!seen_rv && n_wait < TO + 50) begin
      @(negedge clk);
      n_wait++;
      seen_rv = res_valid;
    end
    check("to_res_valid", seen_rv, 1);
    check("to_latency", n_wait, TO + 1);
    check("to_res_class", res_class, 0);
    check("to_res_timeout", res_timeout, 1);
    pulse_ready();

    // Reset at stream index 7 with a partial next frame pending.
    write_frame(8'd50);
    for (int k = 1; k <= 5; k++) write_sample(8'(100 + k));
    seen_rv = 1'b0;
    for (int i = 0; i < 100 && !seen_rv; i++) begin
      @(negedge clk);
      seen_rv = (ecg_out == 8'd58);
    end
    check("c_reach_idx7", seen_rv, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("c_rst_ecg", ecg_out, 0);
    check("c_rst_in_ready", in_ready, 1);
    check("c_rst_res_valid", res_valid, 0);
    write_frame(8'hC0);
    wait_start("c_start");
    expect_stream("c_ecg", 8'hC0);
    tick();
    pulse_done(4'hA);
    @(negedge clk);
    check("c_res_class", res_class, 4'hA);
    check("c_res_timeout", res_timeout, 0);
    pulse_ready();
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
